// File: rtl/demux_1x4_16bit_reg.sv
// demux_1x4_16bit_reg: 1-to-4 write demux into a 4-entry register bank with write strobes and written flags.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   D, A1:A0    - write data and register select (A0 = LSB)
//   WE, CLR     - write enable; synchronous clear (CLR wins over WE)
//   Q0..Q3      - registered bank contents
//   WR_STB      - one-hot strobe of the register written on the last edge
//   WRITTEN     - sticky per-register written flags; ALL_WR = all four set
module demux_1x4_16bit_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             A0,
  input  logic             A1,
  input  logic             WE,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [3:0]       WR_STB,
  output logic [3:0]       WRITTEN,
  output logic             ALL_WR
);
  logic [WIDTH-1:0] q_q [4];
  logic [WIDTH-1:0] q_d [4];
  logic [3:0]       stb_q, stb_d, wr_q, wr_d;
  logic [1:0]       sel;
  always_comb begin
    sel   = {A1, A0};
    stb_d = (CLR || !WE) ? 4'b0000 : 4'b0001 << sel;
    wr_d  = CLR ? 4'b0000 : wr_q | stb_d;
    for (int i = 0; i < 4; i++)
      q_d[i] = CLR ? RESET_VAL : stb_d[i] ? D : q_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q_q[i] <= RESET_VAL;
      stb_q <= '0;
      wr_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) q_q[i] <= q_d[i];
      stb_q <= stb_d;
      wr_q  <= wr_d;
    end
  end
  assign Q0      = q_q[0];
  assign Q1      = q_q[1];
  assign Q2      = q_q[2];
  assign Q3      = q_q[3];
  assign WR_STB  = stb_q;
  assign WRITTEN = wr_q;
  assign ALL_WR  = &wr_q;
endmodule

// File: tb/tb_demux_1x4_16bit_reg.sv
// tb_demux_1x4_16bit_reg: directed self-checking bench for demux_1x4_16bit_reg.
module tb_demux_1x4_16bit_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] D = '0;
  logic        A0 = 1'b0, A1 = 1'b0, WE = 1'b0, CLR = 1'b0;
  logic [15:0] Q0, Q1, Q2, Q3;
  logic [3:0]  WR_STB, WRITTEN;
  logic        ALL_WR;
  logic [72:0] obs;
  int          nvec = 0;
  int          nerr = 0;
  demux_1x4_16bit_reg dut (
    .clk(clk), .rst_n(rst_n), .D(D), .A0(A0), .A1(A1), .WE(WE), .CLR(CLR),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .WR_STB(WR_STB), .WRITTEN(WRITTEN), .ALL_WR(ALL_WR)
  );
  always #5 clk = ~clk;
  assign obs = {Q3, Q2, Q1, Q0, WR_STB, WRITTEN, ALL_WR};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [1:0] a, input logic [15:0] d);
    WE = we;
    {A1, A0} = a;
    D = d;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (obs !== 73'h0) begin
        nerr++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, 73'h0);
      end
    end
    drive(1'b0, 2'd0, 16'h0);
    rst_n = 1'b1;
  endtask
  task automatic test_single_writes();
    logic [15:0] d [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    logic [72:0] e [4] = '{
      {16'h0000, 16'h0000, 16'h0000, 16'hA001, 4'b0001, 4'b0001, 1'b0},
      {16'h0000, 16'h0000, 16'hB002, 16'hA001, 4'b0010, 4'b0011, 1'b0},
      {16'h0000, 16'hC003, 16'hB002, 16'hA001, 4'b0100, 4'b0111, 1'b0},
      {16'hD004, 16'hC003, 16'hB002, 16'hA001, 4'b1000, 4'b1111, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), d[i]);
      step();
      nvec++;
      if (obs !== e[i]) begin
        nerr++;
        $display("FAIL write_sel%0d: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask
  task automatic test_idle();
    logic [72:0] e = {16'hD004, 16'hC003, 16'hB002, 16'hA001, 4'b0000, 4'b1111, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 16'($urandom));
      step();
      nvec++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL idle[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] d [3] = '{16'h1234, 16'h5678, 16'h0000};
    logic        we [3] = '{1'b1, 1'b1, 1'b0};
    logic [72:0] e [3] = '{
      {16'hD004, 16'h1234, 16'hB002, 16'hA001, 4'b0100, 4'b1111, 1'b1},
      {16'hD004, 16'h5678, 16'hB002, 16'hA001, 4'b0100, 4'b1111, 1'b1},
      {16'hD004, 16'h5678, 16'hB002, 16'hA001, 4'b0000, 4'b1111, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      drive(we[i], 2'd2, d[i]);
      step();
      nvec++;
      if (obs !== e[i]) begin
        nerr++;
        $display("FAIL overwrite[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask
  task automatic test_clr();
    drive(1'b1, 2'd1, 16'hBEEF);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    drive(1'b0, 2'd0, 16'h0);
    nvec++;
    if (obs !== 73'h0) begin
      nerr++;
      $display("FAIL clr_priority: got %h expected %h", obs, 73'h0);
    end
    nvec++;
    if (Q1 === 16'hBEEF) begin
      nerr++;
      $display("FAIL clr_q1: got %h expected not %h", Q1, 16'hBEEF);
    end
  endtask
  task automatic test_async_reset();
    logic [72:0] e0 = {16'h7777, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 4'b1000, 1'b0};
    logic [72:0] e1 = {16'h0000, 16'h0000, 16'h0000, 16'h0042, 4'b0001, 4'b0001, 1'b0};
    drive(1'b1, 2'd3, 16'h7777);
    step();
    nvec++;
    if (obs !== e0) begin
      nerr++;
      $display("FAIL write_q3: got %h expected %h", obs, e0);
    end
    drive(1'b0, 2'd0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (obs !== 73'h0) begin
      nerr++;
      $display("FAIL async_reset: got %h expected %h", obs, 73'h0);
    end
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 16'h0042);
    step();
    nvec++;
    if (obs !== e1) begin
      nerr++;
      $display("FAIL post_reset_write: got %h expected %h", obs, e1);
    end
    drive(1'b0, 2'd0, 16'h0);
  endtask
  initial begin
    test_reset();
    test_single_writes();
    test_idle();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
